// File: rtl/range_alu_seq.sv
// Multi-cycle ALU: modulo, range sum, range average and multiply,
// with a valid/ready command port and a valid/ready result port.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : command handshake (op0, op1, sel)
//   out_valid/out_ready : result handshake (res, err)
module range_alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  op0,
  input  logic [7:0]  op1,
  input  logic [1:0]  sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, MOD, SUM, DIV, MUL, DONE
  } st_t;

  st_t         st;
  logic        armed;
  logic        avg;
  logic [15:0] a;
  logic [15:0] b;
  logic [8:0]  idx;
  logic [8:0]  nreg;
  logic [8:0]  r;
  logic [7:0]  m;
  logic [3:0]  cnt;

  logic [15:0] sum_nx;
  logic [15:0] mul_nx;
  logic [9:0]  rsh;
  logic        ge;
  logic [8:0]  r_nx;
  logic [15:0] q_nx;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready  = armed && (st == IDLE);
  assign out_valid = (st == DONE);

  assign sum_nx = a + {7'd0, idx};
  assign mul_nx = m[0] ? a + b : a;

  // restoring division step: a shifts the dividend out, quotient in
  assign rsh  = {r, a[15]};
  assign ge   = rsh >= {1'b0, nreg};
  assign r_nx = ge ? rsh[8:0] - nreg : rsh[8:0];
  assign q_nx = {a[14:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      armed <= 1'b0;
      avg   <= 1'b0;
      a     <= '0;
      b     <= '0;
      idx   <= '0;
      nreg  <= '0;
      r     <= '0;
      m     <= '0;
      cnt   <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            avg  <= (sel == 2'b10);
            b    <= {8'd0, op1};
            m    <= op1;
            cnt  <= '0;
            r    <= '0;
            nreg <= {1'b0, op1} - {1'b0, op0} + 9'd1;
            unique case (sel)
              2'b00: begin
                if (op1 == 8'd0) begin
                  res <= '0;
                  err <= 1'b1;
                  st  <= DONE;
                end else begin
                  a  <= {8'd0, op0};
                  st <= MOD;
                end
              end
              2'b01, 2'b10: begin
                if (op0 > op1) begin
                  res <= '0;
                  err <= sel[1];
                  st  <= DONE;
                end else begin
                  a   <= '0;
                  idx <= {1'b0, op0};
                  st  <= SUM;
                end
              end
              2'b11: begin
                a  <= '0;
                b  <= {8'd0, op0};
                st <= MUL;
              end
            endcase
          end
        end
        MOD: begin
          if (a >= b) begin
            a <= a - b;
          end else begin
            res <= a;
            err <= 1'b0;
            st  <= DONE;
          end
        end
        SUM: begin
          a   <= sum_nx;
          idx <= idx + 9'd1;
          if (idx == {1'b0, b[7:0]}) begin
            if (avg) begin
              cnt <= '0;
              r   <= '0;
              st  <= DIV;
            end else begin
              res <= sum_nx;
              err <= 1'b0;
              st  <= DONE;
            end
          end
        end
        DIV: begin
          r   <= r_nx;
          a   <= q_nx;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            res <= q_nx;
            err <= 1'b0;
            st  <= DONE;
          end
        end
        MUL: begin
          a   <= mul_nx;
          b   <= {b[14:0], 1'b0};
          m   <= {1'b0, m[7:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            res <= mul_nx;
            err <= 1'b0;
            st  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_alu_seq.sv
// Randomized bench for range_alu_seq with a transaction-level model
// checked every cycle, plus directed literal cases.
module tb_range_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  op0 = '0;
  logic [7:0]  op1 = '0;
  logic [1:0]  sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] res;
  logic        err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit rnd_or = 1'b0;

  range_alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op0(op0), .op1(op1), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // transaction model: result value and compute latency per command
  int  m_busy;
  bit  m_done;
  bit  m_armed;
  int  m_res;
  bit  m_err;
  int  p_res;
  bit  p_err;

  task automatic golden(input int a, input int b, input int s,
                        output int r, output bit e, output int lat);
    int n;
    r = 0; e = 1'b0; lat = 0;
    case (s)
      0: if (b == 0) e = 1'b1;
         else begin r = a % b; lat = a / b + 1; end
      1: if (a <= b) begin
           n = b - a + 1; r = (a + b) * n / 2; lat = n;
         end
      2: if (a > b) e = 1'b1;
         else begin
           n = b - a + 1; r = ((a + b) * n / 2) / n; lat = n + 16;
         end
      default: begin r = a * b; lat = 8; end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    int r, lat;
    bit e;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_armed = 0;
      m_res = 0; m_err = 0;
    end else begin
      if (m_done) begin
        if (out_ready) m_done = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_done = 1; m_res = p_res; m_err = p_err;
        end
      end else if (m_armed && in_valid) begin
        golden(op0, op1, sel, r, e, lat);
        p_res = r; p_err = e;
        if (lat == 0) begin
          m_done = 1; m_res = r; m_err = e;
        end else m_busy = lat;
      end
      m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_armed && m_busy == 0 && !m_done);
      chk("out_valid", out_valid, m_done);
      chk("res", res, m_res);
      chk("err", err, m_err);
    end
  end

  always @(posedge clk) begin
    if (rnd_or) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic cmd(input int a, input int b, input int s,
                     input int lat, input int xr, input bit xe);
    int n = 0;
    wait_ready();
    in_valid = 1; op0 = 8'(a); op1 = 8'(b); sel = 2'(s);
    @(posedge clk); #1;
    in_valid = 0;
    op0 = 8'($urandom); op1 = 8'($urandom); sel = 2'($urandom);
    while (!out_valid && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, lat);
    chk("lit_res", res, xr);
    chk("lit_err", err, xe);
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_ack", out_valid, 0);
    chk("ready_after_ack", in_ready, 1);
  endtask

  initial begin
    int a, b, s;
    int n;
    bit seen;
    logic [15:0] hold;
    #1 chk_en = 1;
    chk("rst_res", res, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1 chk("ready_pre_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_post_edge", in_ready, 1);

    cmd(23, 5, 0, 5, 3, 0);
    drain();
    cmd(0, 255, 1, 256, 32640, 0);
    drain();
    cmd(3, 6, 2, 20, 4, 0);
    drain();
    cmd(9, 2, 2, 0, 0, 1);
    drain();
    cmd(255, 255, 3, 8, 65025, 0);
    hold = res;
    repeat (10) begin
      @(posedge clk); #1;
      if (res !== hold || out_valid !== 1'b1) begin
        chk("hold_stable", res, hold);
      end
    end
    chk("hold_res", res, 65025);
    drain();
    cmd(200, 7, 1, 0, 0, 0);
    drain();
    cmd(0, 0, 2, 17, 0, 0);
    drain();

    // command held on in_valid across DONE must not be taken twice
    wait_ready();
    in_valid = 1; op0 = 7; op1 = 0; sel = 0;
    @(posedge clk); #1;
    chk("mod0_valid", out_valid, 1);
    chk("mod0_res", res, 0);
    chk("mod0_err", err, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 chk("no_second_capture", out_valid, 0);

    // abort a range sum with a reset
    wait_ready();
    in_valid = 1; op0 = 0; op1 = 200; sel = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (49) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_res", res, 0);
    chk("abort_err", err, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_valid", out_valid, 0);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    chk("abort_ready_rel", in_ready, 1);
    seen = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_result", seen, 0);

    rnd_or = 1;
    for (int k = 0; k < 120; k++) begin
      s = $urandom_range(0, 3);
      a = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 255);
        1: b = (a + $urandom_range(0, 30) > 255) ? 255
                : a + $urandom_range(0, 30);
        2: b = $urandom_range(0, 3);
        default: b = (a > 5) ? a - $urandom_range(0, 5) : a;
      endcase
      wait_ready();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (in_ready) begin
        in_valid = 1; op0 = 8'(a); op1 = 8'(b); sel = 2'(s);
        @(posedge clk); #1;
        in_valid = 0; op0 = 8'($urandom);
      end
    end
    n = 0;
    while ((out_valid || !in_ready) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    rnd_or = 0;
    chk("drain_timeout", n < 1000, 1);
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
